// File: rtl/control_fsm_if.sv
// Control-signal bundle between the control FSM and the decode/datapath/memory side.
// The master (control unit) sees the decoded IR fields and memory/branch status
// and drives every strobe and select.
interface control_fsm_if;
  logic [6:0] opcode;
  logic [2:0] f3;
  logic       mem_complete;
  logic       branch_taken;

  logic       write_pc_ne;
  logic       write_pc_ex;
  logic       write_pc;
  logic       write_ir;
  logic       write_rd;
  logic       write_csr;
  logic       mem_read;
  logic       mem_write;
  logic       addr_sel;
  logic [1:0] rd_sel;
  logic [1:0] alu_insel1;
  logic [1:0] alu_insel2;
  logic       retire;
  logic [1:0] fault;

  modport master (
    input  opcode, f3, mem_complete, branch_taken,
    output write_pc_ne, write_pc_ex, write_pc, write_ir, write_rd, write_csr,
           mem_read, mem_write, addr_sel, rd_sel, alu_insel1, alu_insel2, retire, fault
  );

  modport slave (
    output opcode, f3, mem_complete, branch_taken,
    input  write_pc_ne, write_pc_ex, write_pc, write_ir, write_rd, write_csr,
           mem_read, mem_write, addr_sel, rd_sel, alu_insel1, alu_insel2, retire, fault
  );
endinterface

// File: rtl/control_fsm.sv
// Multi-cycle RV32I control unit. One instruction in flight: FETCH -> DECODE -> EXEC
// (-> MEM for loads/stores) -> FETCH, with debug halt/resume/single-step taken only at
// instruction boundaries and an optional memory-access timeout that parks the core in HALT.
module control_fsm #(
  parameter bit          RESET_HALTED = 1'b0,
  parameter int unsigned MEM_TIMEOUT  = 0,
  parameter int unsigned TIMEOUT_W    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          halt_req,
  input  logic          resume_req,
  input  logic          step_req,
  output logic          halted,
  control_fsm_if.master ctrl
);

  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam bit                   TmoEn    = (MEM_TIMEOUT != 0);
  localparam logic [TIMEOUT_W-1:0] TmoLimit = (MEM_TIMEOUT == 0) ? '0 :
                                              TIMEOUT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StHalt
  } state_e;

  state_e               state_q, state_d;
  logic                 step_q, step_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;

  // Internal (pre-reset-gating) versions of the outputs.
  logic       pc_ne, pc_ex, ir_wr, rd_wr, csr_wr, mrd, mwr, asel, hlt, ret;
  logic [1:0] rdsel, alu1, alu2, flt;
  logic       tmo_hit;
  state_e     boundary_st;

  // Limit cycle reached with the access still outstanding; a completion wins.
  assign tmo_hit = TmoEn && (tmo_q == TmoLimit) && !ctrl.mem_complete;

  // Where a retiring instruction goes: debugger halt or pending single step park us.
  assign boundary_st = (halt_req || step_q) ? StHalt : StFetch;

  // Next-state and control decode.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    pc_ne   = 1'b0;
    pc_ex   = 1'b0;
    ir_wr   = 1'b0;
    rd_wr   = 1'b0;
    csr_wr  = 1'b0;
    mrd     = 1'b0;
    mwr     = 1'b0;
    asel    = 1'b0;
    hlt     = 1'b0;
    rdsel   = 2'b00;
    alu1    = 2'b00;
    alu2    = 2'b00;
    flt     = 2'b00;

    unique case (state_q)
      StFetch: begin
        asel = 1'b1;
        mrd  = 1'b1;
        if (ctrl.mem_complete) begin
          ir_wr   = 1'b1;
          state_d = StDecode;
        end else if (tmo_hit) begin
          flt     = 2'b10;
          state_d = StHalt;
        end
      end

      StDecode: state_d = StExec;

      StExec: begin
        case (ctrl.opcode)
          OpOp: begin
            rd_wr = 1'b1;
            pc_ne = 1'b1;
          end
          OpOpImm: begin
            // Shift-immediates take the shamt field instead of the full immediate.
            alu2  = (ctrl.f3 == 3'b001 || ctrl.f3 == 3'b101) ? 2'b10 : 2'b01;
            rd_wr = 1'b1;
            pc_ne = 1'b1;
          end
          OpLui: begin
            alu1  = 2'b10;
            alu2  = 2'b01;
            rd_wr = 1'b1;
            pc_ne = 1'b1;
          end
          OpAuipc: begin
            alu1  = 2'b01;
            alu2  = 2'b01;
            rd_wr = 1'b1;
            pc_ne = 1'b1;
          end
          OpJal, OpJalr: begin
            alu1  = (ctrl.opcode == OpJal) ? 2'b01 : 2'b00;
            alu2  = 2'b01;
            rdsel = 2'b11;
            rd_wr = 1'b1;
            pc_ex = 1'b1;
          end
          OpBranch: begin
            alu1  = 2'b01;
            alu2  = 2'b01;
            pc_ex = ctrl.branch_taken;
            pc_ne = !ctrl.branch_taken;
          end
          OpLoad, OpStore: begin
            alu2    = 2'b01;
            state_d = StMem;
          end
          OpFence: pc_ne = 1'b1;
          OpSystem: begin
            if (ctrl.f3 != 3'b000) begin
              rdsel  = 2'b10;
              rd_wr  = 1'b1;
              csr_wr = 1'b1;
              pc_ne  = 1'b1;
            end else begin
              // ECALL/EBREAK hand control to the debugger without retiring.
              state_d = StHalt;
            end
          end
          default: begin
            flt     = 2'b01;
            state_d = StHalt;
          end
        endcase
      end

      StMem: begin
        alu2 = 2'b01;
        mrd  = (ctrl.opcode == OpLoad);
        mwr  = (ctrl.opcode != OpLoad);
        if (ctrl.mem_complete) begin
          if (ctrl.opcode == OpLoad) begin
            rd_wr = 1'b1;
            rdsel = 2'b01;
          end
          pc_ne = 1'b1;
        end else if (tmo_hit) begin
          flt     = 2'b10;
          state_d = StHalt;
        end
      end

      StHalt: begin
        hlt = 1'b1;
        if (halt_req) begin
          state_d = StHalt;
        end else if (step_req) begin
          state_d = StFetch;
          step_d  = 1'b1;
        end else if (resume_req) begin
          state_d = StFetch;
        end
      end

      default: state_d = StHalt;
    endcase

    ret = pc_ne | pc_ex;
    if (ret) begin
      state_d = boundary_st;
      step_d  = 1'b0;
    end
    // A stale step flag must not survive a fault/ebreak halt.
    if (state_d == StHalt && state_q != StHalt) begin
      step_d = 1'b0;
    end
  end

  // Timeout counter: counts stalled access cycles, restarts on every state change.
  always_comb begin
    tmo_d = tmo_q;
    if (!TmoEn || state_d != state_q) begin
      tmo_d = '0;
    end else if ((state_q == StFetch || state_q == StMem) && !ctrl.mem_complete) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Output drive; reset forces every strobe low in the same cycle.
  always_comb begin
    halted           = hlt & ~rst;
    ctrl.write_pc_ne = pc_ne & ~rst;
    ctrl.write_pc_ex = pc_ex & ~rst;
    ctrl.write_pc    = ret & ~rst;
    ctrl.retire      = ret & ~rst;
    ctrl.write_ir    = ir_wr & ~rst;
    ctrl.write_rd    = rd_wr & ~rst;
    ctrl.write_csr   = csr_wr & ~rst;
    ctrl.mem_read    = mrd & ~rst;
    ctrl.mem_write   = mwr & ~rst;
    ctrl.addr_sel    = asel & ~rst;
    ctrl.rd_sel      = rst ? 2'b00 : rdsel;
    ctrl.alu_insel1  = rst ? 2'b00 : alu1;
    ctrl.alu_insel2  = rst ? 2'b00 : alu2;
    ctrl.fault       = rst ? 2'b00 : flt;
  end

  // State, step flag and timeout count registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_HALTED ? StHalt : StFetch;
      step_q  <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: table of single instructions, randomized instruction stream
// checked against an instruction-level trace model, and hand sequences for debug,
// timeout and fault corner cases.
module tb_control_fsm;

  localparam logic [6:0] OP_ = 7'b0110011, OPI = 7'b0010011, LUI = 7'b0110111;
  localparam logic [6:0] AUI = 7'b0010111, JAL = 7'b1101111, JLR = 7'b1100111;
  localparam logic [6:0] BR  = 7'b1100011, LD  = 7'b0000011, ST  = 7'b0100011;
  localparam logic [6:0] FEN = 7'b0001111, SYS = 7'b1110011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, halt_req, resume_req, step_req, halted, halted_h;

  control_fsm_if ifc ();
  control_fsm_if ifh ();

  assign ifh.opcode       = ifc.opcode;
  assign ifh.f3           = ifc.f3;
  assign ifh.mem_complete = ifc.mem_complete;
  assign ifh.branch_taken = ifc.branch_taken;

  control_fsm #(.RESET_HALTED(1'b0), .MEM_TIMEOUT(4), .TIMEOUT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .halt_req   (halt_req),
    .resume_req (resume_req),
    .step_req   (step_req),
    .halted     (halted),
    .ctrl       (ifc.master)
  );

  control_fsm #(.RESET_HALTED(1'b1), .MEM_TIMEOUT(0), .TIMEOUT_W(8)) dut_h (
    .clk        (clk),
    .rst        (rst),
    .halt_req   (halt_req),
    .resume_req (resume_req),
    .step_req   (step_req),
    .halted     (halted_h),
    .ctrl       (ifh.master)
  );

  typedef struct packed {
    logic       halted;
    logic       pc_ne;
    logic       pc_ex;
    logic       pc;
    logic       ir;
    logic       rd;
    logic       csr;
    logic       mrd;
    logic       mwr;
    logic       asel;
    logic [1:0] rdsel;
    logic [1:0] a1;
    logic [1:0] a2;
    logic       retire;
    logic [1:0] fault;
  } out_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       taken;
    out_t       ex;
    string      name;
  } vec_t;

  int checks = 0;
  int errors = 0;

  function automatic out_t sample();
    out_t o;
    o.halted = halted;
    o.pc_ne  = ifc.write_pc_ne;
    o.pc_ex  = ifc.write_pc_ex;
    o.pc     = ifc.write_pc;
    o.ir     = ifc.write_ir;
    o.rd     = ifc.write_rd;
    o.csr    = ifc.write_csr;
    o.mrd    = ifc.mem_read;
    o.mwr    = ifc.mem_write;
    o.asel   = ifc.addr_sel;
    o.rdsel  = ifc.rd_sel;
    o.a1     = ifc.alu_insel1;
    o.a2     = ifc.alu_insel2;
    o.retire = ifc.retire;
    o.fault  = ifc.fault;
    return o;
  endfunction

  // Expected outputs for one phase of an instruction.
  function automatic out_t mk(logic pc_ne, logic pc_ex, logic rd, logic csr, logic [1:0] rdsel,
                              logic [1:0] a1, logic [1:0] a2);
    out_t o = '0;
    o.pc_ne = pc_ne;
    o.pc_ex = pc_ex;
    o.pc = pc_ne | pc_ex;
    o.retire = pc_ne | pc_ex;
    o.rd = rd;
    o.csr = csr;
    o.rdsel = rdsel;
    o.a1 = a1;
    o.a2 = a2;
    return o;
  endfunction

  function automatic out_t o_fetch(logic c);
    out_t o = '0;
    o.asel = 1'b1;
    o.mrd = 1'b1;
    o.ir = c;
    return o;
  endfunction

  function automatic out_t o_halt();
    out_t o = '0;
    o.halted = 1'b1;
    return o;
  endfunction

  function automatic out_t o_mem(logic is_load, logic c);
    out_t o = mk(c, 1'b0, is_load & c, 1'b0, (is_load & c) ? 2'b01 : 2'b00, 2'b00, 2'b01);
    o.mrd = is_load;
    o.mwr = !is_load;
    return o;
  endfunction

  // Reference for the EXEC cycle, from the instruction-class rules.
  function automatic out_t o_exec(logic [6:0] op, logic [2:0] f3, logic taken);
    out_t o;
    case (op)
      OP_:     o = mk(1, 0, 1, 0, 2'd0, 2'd0, 2'd0);
      OPI:     o = mk(1, 0, 1, 0, 2'd0, 2'd0, (f3 == 3'd1 || f3 == 3'd5) ? 2'd2 : 2'd1);
      LUI:     o = mk(1, 0, 1, 0, 2'd0, 2'd2, 2'd1);
      AUI:     o = mk(1, 0, 1, 0, 2'd0, 2'd1, 2'd1);
      JAL:     o = mk(0, 1, 1, 0, 2'd3, 2'd1, 2'd1);
      JLR:     o = mk(0, 1, 1, 0, 2'd3, 2'd0, 2'd1);
      BR:      o = mk(!taken, taken, 0, 0, 2'd0, 2'd1, 2'd1);
      LD, ST:  o = mk(0, 0, 0, 0, 2'd0, 2'd0, 2'd1);
      FEN:     o = mk(1, 0, 0, 0, 2'd0, 2'd0, 2'd0);
      SYS:     o = (f3 != 3'd0) ? mk(1, 0, 1, 1, 2'd2, 2'd0, 2'd0) : '0;
      default: begin
        o = '0;
        o.fault = 2'b01;
      end
    endcase
    return o;
  endfunction

  task automatic check(out_t exp, string name);
    out_t got;
    got = sample();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %05h expected %05h", name, got, exp);
    end
  endtask

  // One clock: drive inputs on the falling edge, check outputs 1ns later.
  task automatic cyc(logic [6:0] op, logic [2:0] f3, logic taken, logic mc, logic hreq,
                     logic rreq, logic sreq, out_t exp, string name);
    @(negedge clk);
    rst = 1'b0;
    ifc.opcode = op;
    ifc.f3 = f3;
    ifc.branch_taken = taken;
    ifc.mem_complete = mc;
    halt_req = hreq;
    resume_req = rreq;
    step_req = sreq;
    #1;
    check(exp, name);
  endtask

  task automatic rcyc(logic mc, string name);
    @(negedge clk);
    rst = 1'b1;
    ifc.mem_complete = mc;
    #1;
    check('0, name);
  endtask

  // Full instruction trace: fw fetch cycles, decode, exec, then mw memory cycles.
  task automatic run_instr(logic [6:0] op, logic [2:0] f3, logic taken, out_t ex,
                           int fw, int mw, logic hreq, string name);
    for (int k = 0; k < fw; k++)
      cyc(op, f3, taken, k == fw - 1, 0, 0, 0, o_fetch(k == fw - 1), {name, "/fetch"});
    cyc(op, f3, taken, 0, hreq, 0, 0, '0, {name, "/decode"});
    cyc(op, f3, taken, 0, hreq, 0, 0, ex, {name, "/exec"});
    if (op == LD || op == ST)
      for (int k = 0; k < mw; k++)
        cyc(op, f3, taken, k == mw - 1, hreq, 0, 0, o_mem(op == LD, k == mw - 1),
            {name, "/mem"});
  endtask

  vec_t vecs[14];
  logic [6:0] ops[11];

  initial begin
    vecs[0]  = '{OPI, 3'd0, 1'b0, mk(1, 0, 1, 0, 2'd0, 2'd0, 2'd1), "addi"};
    vecs[1]  = '{OPI, 3'd1, 1'b0, mk(1, 0, 1, 0, 2'd0, 2'd0, 2'd2), "slli"};
    vecs[2]  = '{OPI, 3'd5, 1'b0, mk(1, 0, 1, 0, 2'd0, 2'd0, 2'd2), "srai"};
    vecs[3]  = '{OP_, 3'd0, 1'b0, mk(1, 0, 1, 0, 2'd0, 2'd0, 2'd0), "add"};
    vecs[4]  = '{LUI, 3'd3, 1'b0, mk(1, 0, 1, 0, 2'd0, 2'd2, 2'd1), "lui"};
    vecs[5]  = '{AUI, 3'd0, 1'b0, mk(1, 0, 1, 0, 2'd0, 2'd1, 2'd1), "auipc"};
    vecs[6]  = '{JAL, 3'd0, 1'b0, mk(0, 1, 1, 0, 2'd3, 2'd1, 2'd1), "jal"};
    vecs[7]  = '{JLR, 3'd0, 1'b1, mk(0, 1, 1, 0, 2'd3, 2'd0, 2'd1), "jalr"};
    vecs[8]  = '{BR,  3'd0, 1'b1, mk(0, 1, 0, 0, 2'd0, 2'd1, 2'd1), "beq_taken"};
    vecs[9]  = '{BR,  3'd1, 1'b0, mk(1, 0, 0, 0, 2'd0, 2'd1, 2'd1), "bne_not_taken"};
    vecs[10] = '{FEN, 3'd0, 1'b0, mk(1, 0, 0, 0, 2'd0, 2'd0, 2'd0), "fence"};
    vecs[11] = '{SYS, 3'd1, 1'b0, mk(1, 0, 1, 1, 2'd2, 2'd0, 2'd0), "csrrw"};
    vecs[12] = '{LD,  3'd2, 1'b0, mk(0, 0, 0, 0, 2'd0, 2'd0, 2'd1), "lw"};
    vecs[13] = '{ST,  3'd2, 1'b0, mk(0, 0, 0, 0, 2'd0, 2'd0, 2'd1), "sw"};
    ops = '{OP_, OPI, LUI, AUI, JAL, JLR, BR, LD, ST, FEN, SYS};

    rst = 1'b1;
    halt_req = 1'b0;
    resume_req = 1'b0;
    step_req = 1'b0;
    ifc.opcode = 7'd0;
    ifc.f3 = 3'd0;
    ifc.branch_taken = 1'b0;
    ifc.mem_complete = 1'b0;

    // Reset: everything low even with a completion showing.
    rcyc(1'b0, "reset0");
    rcyc(1'b1, "reset1");

    // ADDI with single-cycle fetch: write_ir@1, retire@3.
    run_instr(OPI, 3'd0, 1'b0, mk(1, 0, 1, 0, 2'd0, 2'd0, 2'd1), 1, 1, 1'b0, "addi_first");
    checks++;
    if (halted_h !== 1'b1) begin
      errors++;
      $display("FAIL reset_halted: got %b expected 1", halted_h);
    end

    // Reset in the middle of a fetch drops mem_read in the same cycle.
    cyc(OPI, 3'd0, 0, 0, 0, 0, 0, o_fetch(1'b0), "mid_fetch");
    rcyc(1'b0, "mid_fetch_reset");
    run_instr(OPI, 3'd0, 1'b0, mk(1, 0, 1, 0, 2'd0, 2'd0, 2'd1), 2, 1, 1'b0, "after_reset");

    // Table of single instructions.
    for (int i = 0; i < 14; i++)
      run_instr(vecs[i].op, vecs[i].f3, vecs[i].taken, vecs[i].ex, 1, 1, 1'b0, vecs[i].name);

    // LW with a 3-cycle memory: mem_read high three MEM cycles, retire on the 6th cycle.
    run_instr(LD, 3'd2, 1'b0, o_exec(LD, 3'd2, 1'b0), 1, 3, 1'b0, "lw_wait3");

    // Randomized instruction stream with random memory latencies.
    for (int n = 0; n < 40; n++) begin
      logic [6:0] op;
      logic [2:0] f3;
      logic       tk;
      op = ops[$urandom_range(0, 10)];
      f3 = 3'($urandom_range(0, 7));
      if (op == SYS) f3 = 3'($urandom_range(1, 7));
      tk = 1'($urandom_range(0, 1));
      run_instr(op, f3, tk, o_exec(op, f3, tk), $urandom_range(1, 3), $urandom_range(1, 3),
                1'b0, $sformatf("rand%0d_op%07b", n, op));
    end

    // halt_req raised mid-LW: the load completes, then HALT; resume restarts fetch next cycle.
    run_instr(LD, 3'd2, 1'b0, o_exec(LD, 3'd2, 1'b0), 1, 2, 1'b1, "lw_halt");
    cyc(OPI, 3'd0, 0, 0, 1, 0, 0, o_halt(), "halt_hold");
    cyc(OPI, 3'd0, 0, 0, 0, 1, 0, o_halt(), "halt_resume");
    run_instr(OPI, 3'd0, 1'b0, o_exec(OPI, 3'd0, 1'b0), 1, 1, 1'b0, "after_resume");

    // EBREAK halts without retiring; halt+resume stays halted; step+resume runs one ADDI.
    run_instr(SYS, 3'd0, 1'b0, '0, 1, 1, 1'b0, "ebreak");
    cyc(OPI, 3'd0, 0, 0, 1, 1, 0, o_halt(), "halt_beats_resume0");
    cyc(OPI, 3'd0, 0, 0, 1, 1, 0, o_halt(), "halt_beats_resume1");
    cyc(OPI, 3'd0, 0, 0, 0, 1, 1, o_halt(), "step_req");
    run_instr(OPI, 3'd0, 1'b0, o_exec(OPI, 3'd0, 1'b0), 1, 1, 1'b0, "stepped_addi");
    cyc(OPI, 3'd0, 0, 0, 0, 0, 0, o_halt(), "after_step0");
    cyc(OPI, 3'd0, 0, 0, 0, 0, 0, o_halt(), "after_step1");
    cyc(OPI, 3'd0, 0, 0, 0, 1, 0, o_halt(), "resume_after_step");

    // SW that never completes: fault=10 on the 4th MEM cycle, no PC write, then HALT.
    cyc(ST, 3'd2, 0, 1, 0, 0, 0, o_fetch(1'b1), "sw_tmo/fetch");
    cyc(ST, 3'd2, 0, 0, 0, 0, 0, '0, "sw_tmo/decode");
    cyc(ST, 3'd2, 0, 0, 0, 0, 0, o_exec(ST, 3'd2, 1'b0), "sw_tmo/exec");
    for (int k = 0; k < 3; k++)
      cyc(ST, 3'd2, 0, 0, 0, 0, 0, o_mem(1'b0, 1'b0), "sw_tmo/mem_wait");
    begin
      out_t e;
      e = o_mem(1'b0, 1'b0);
      e.fault = 2'b10;
      cyc(ST, 3'd2, 0, 0, 0, 0, 0, e, "sw_tmo/fault");
    end
    cyc(ST, 3'd2, 0, 0, 0, 0, 0, o_halt(), "sw_tmo/halted");
    cyc(ST, 3'd2, 0, 0, 0, 1, 0, o_halt(), "sw_tmo/resume");

    // Illegal opcode: fault=01 in EXEC, PC untouched, then HALT.
    begin
      out_t e;
      e = '0;
      e.fault = 2'b01;
      run_instr(7'b0000000, 3'd0, 1'b0, e, 1, 1, 1'b0, "illegal");
    end
    cyc(OPI, 3'd0, 0, 0, 0, 0, 0, o_halt(), "illegal/halted");
    cyc(OPI, 3'd0, 0, 0, 0, 1, 0, o_halt(), "illegal/resume");
    run_instr(OPI, 3'd0, 1'b0, o_exec(OPI, 3'd0, 1'b0), 1, 1, 1'b0, "final_addi");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
